// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for regfile_scoreboard: read ports, scoreboard query,
// issue strobe and writeback strobe.
interface regfile_scoreboard_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
);
  logic [AW-1:0]    RS;
  logic [AW-1:0]    RT;
  logic [WIDTH-1:0] ReadRS;
  logic [WIDTH-1:0] ReadRT;
  logic             UseRS;
  logic             UseRT;
  logic             BusyRS;
  logic             BusyRT;
  logic             Hazard;
  logic             IssueValid;
  logic [AW-1:0]    IssueRD;
  logic             RegWrite;
  logic [AW-1:0]    RD;
  logic [WIDTH-1:0] WriteData;

  // IssueValid and RegWrite are single-cycle strobes with no ready: the register
  // file always accepts them at the rising edge where they are high.
  modport master (
    output RS, RT, UseRS, UseRT, IssueValid, IssueRD, RegWrite, RD, WriteData,
    input  ReadRS, ReadRT, BusyRS, BusyRT, Hazard
  );

  modport slave (
    input  RS, RT, UseRS, UseRT, IssueValid, IssueRD, RegWrite, RD, WriteData,
    output ReadRS, ReadRT, BusyRS, BusyRT, Hazard
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with a one-bit-per-register busy scoreboard for RAW
// hazard detection. Optional same-cycle write bypass: define WRITE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  regfile_scoreboard_if.slave  bus
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Writeback clears busy first so a same-edge issue to the same register wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (bus.RegWrite) begin
      regs_d[bus.RD] = bus.WriteData;
      busy_d[bus.RD] = 1'b0;
    end
    if (bus.IssueValid) begin
      busy_d[bus.IssueRD] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  logic [WIDTH-1:0] read_rs;
  logic [WIDTH-1:0] read_rt;
  logic             busy_rs;
  logic             busy_rt;

  always_comb begin
    read_rs = regs_q[bus.RS];
    read_rt = regs_q[bus.RT];
    busy_rs = busy_q[bus.RS];
    busy_rt = busy_q[bus.RT];
`ifdef WRITE_BYPASS_EN
    if (bus.RegWrite && (bus.RD == bus.RS)) begin
      read_rs = bus.WriteData;
      busy_rs = 1'b0;
    end
    if (bus.RegWrite && (bus.RD == bus.RT)) begin
      read_rt = bus.WriteData;
      busy_rt = 1'b0;
    end
`endif
    // Address 0 must stay zero and idle even against the bypass path.
    if ((ZERO_REG != 0) && (bus.RS == '0)) begin
      read_rs = '0;
      busy_rs = 1'b0;
    end
    if ((ZERO_REG != 0) && (bus.RT == '0)) begin
      read_rt = '0;
      busy_rt = 1'b0;
    end
    if (!Reset_n) begin
      read_rs = '0;
      read_rt = '0;
      busy_rs = 1'b0;
      busy_rt = 1'b0;
    end
  end

  assign bus.ReadRS = read_rs;
  assign bus.ReadRT = read_rt;
  assign bus.BusyRS = busy_rs;
  assign bus.BusyRT = busy_rt;
  assign bus.Hazard = (bus.UseRS & busy_rs) | (bus.UseRT & busy_rt);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic against a
// behavioural model, and a WIDTH=32/DEPTH=16/ZERO_REG=0 instance.
module tb_regfile_scoreboard;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int ZR    = 1;
  localparam int W_W   = 32;
  localparam int W_D   = 16;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  // clock / reset
  always #5 Clock = ~Clock;

  regfile_scoreboard_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  regfile_scoreboard_if #(.WIDTH(W_W), .DEPTH(W_D)) bus_w ();

  regfile_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZR)) u_dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  regfile_scoreboard #(.WIDTH(W_W), .DEPTH(W_D), .ZERO_REG(0)) u_wide (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus_w)
  );

  // reference model: architectural register contents and pending-write flags
  logic [WIDTH-1:0] m_regs [DEPTH];
  bit               m_busy [DEPTH];
  logic [WIDTH-1:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_read(input int a);
    if (ZR != 0 && a == 0) return '0;
`ifdef WRITE_BYPASS_EN
    if (bus.RegWrite && int'(bus.RD) == a) return bus.WriteData;
`endif
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a);
    if (ZR != 0 && a == 0) return 1'b0;
`ifdef WRITE_BYPASS_EN
    if (bus.RegWrite && int'(bus.RD) == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic model_update();
    int rd;
    int ird;
    rd  = int'(bus.RD);
    ird = int'(bus.IssueRD);
    if (bus.RegWrite && !(ZR != 0 && rd == 0)) begin
      m_regs[rd] = bus.WriteData;
      m_busy[rd] = 1'b0;
    end
    if (bus.IssueValid && !(ZR != 0 && ird == 0)) m_busy[ird] = 1'b1;
  endtask

  task automatic check_outputs();
    bit brs;
    bit brt;
    exp_q.push_back(exp_read(int'(bus.RS)));
    exp_q.push_back(exp_read(int'(bus.RT)));
    check_val("ReadRS", 32'(bus.ReadRS), 32'(exp_q.pop_front()));
    check_val("ReadRT", 32'(bus.ReadRT), 32'(exp_q.pop_front()));
    brs = exp_busy(int'(bus.RS));
    brt = exp_busy(int'(bus.RT));
    check_val("BusyRS", 32'(bus.BusyRS), 32'(brs));
    check_val("BusyRT", 32'(bus.BusyRT), 32'(brt));
    check_val("Hazard", 32'(bus.Hazard), 32'((bus.UseRS & brs) | (bus.UseRT & brt)));
  endtask

  // driver tasks; every cycle starts and ends on a falling edge
  task automatic idle();
    bus.RS = '0; bus.RT = '0; bus.UseRS = 1'b0; bus.UseRT = 1'b0;
    bus.IssueValid = 1'b0; bus.IssueRD = '0;
    bus.RegWrite = 1'b0; bus.RD = '0; bus.WriteData = '0;
  endtask

  task automatic idle_w();
    bus_w.RS = '0; bus_w.RT = '0; bus_w.UseRS = 1'b0; bus_w.UseRT = 1'b0;
    bus_w.IssueValid = 1'b0; bus_w.IssueRD = '0;
    bus_w.RegWrite = 1'b0; bus_w.RD = '0; bus_w.WriteData = '0;
  endtask

  task automatic do_cycle();
    #2;
    check_outputs();
    @(posedge Clock);
    model_update();
    @(negedge Clock);
  endtask

  task automatic drive_write(input int rd, input logic [WIDTH-1:0] d);
    bus.RegWrite = 1'b1; bus.RD = AW'(rd); bus.WriteData = d;
  endtask

  task automatic drive_issue(input int rd);
    bus.IssueValid = 1'b1; bus.IssueRD = AW'(rd);
  endtask

  task automatic drive_read(input int rs, input int rt, input logic urs, input logic urt);
    bus.RS = AW'(rs); bus.RT = AW'(rt); bus.UseRS = urs; bus.UseRT = urt;
  endtask

  initial begin
    idle();
    idle_w();
    model_reset();
    #1;
    check_val("reset_ReadRS", 32'(bus.ReadRS), 32'h0);
    check_val("reset_Hazard", 32'(bus.Hazard), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);

    // asynchronous reset mid-cycle after writing R3 and issuing R2
    drive_write(3, 16'hBEEF);
    drive_issue(2);
    do_cycle();
    idle();
    drive_read(3, 2, 1'b1, 1'b1);
    #2;
    check_outputs();
    #1;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_val("async_rst_ReadRS", 32'(bus.ReadRS), 32'h0);
    check_val("async_rst_BusyRS", 32'(bus.BusyRS), 32'h0);
    check_val("async_rst_BusyRT", 32'(bus.BusyRT), 32'h0);
    check_val("async_rst_Hazard", 32'(bus.Hazard), 32'h0);
    @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    do_cycle();

    // write R5 then read on RT
    idle();
    drive_write(5, 16'h1234);
    drive_read(0, 5, 1'b0, 1'b1);
    do_cycle();
    idle();
    drive_read(0, 5, 1'b0, 1'b1);
    #2;
    check_val("r5_after_edge", 32'(bus.ReadRT), 32'h1234);
    do_cycle();

    // hardwired zero register
    idle();
    drive_write(0, 16'hFFFF);
    drive_issue(0);
    drive_read(0, 0, 1'b1, 1'b1);
    do_cycle();
    idle();
    drive_read(0, 0, 1'b1, 1'b1);
    #2;
    check_val("r0_read", 32'(bus.ReadRS), 32'h0);
    check_val("r0_busy", 32'(bus.BusyRS), 32'h0);
    do_cycle();

    // RAW hazard on R2: issue, wait, writeback three edges later
    idle();
    drive_issue(2);
    do_cycle();
    idle();
    drive_read(2, 1, 1'b1, 1'b0);
    #2;
    check_val("r2_busy", 32'(bus.BusyRS), 32'h1);
    check_val("r2_hazard", 32'(bus.Hazard), 32'h1);
    do_cycle();
    do_cycle();
    drive_write(2, 16'h00A5);
    do_cycle();
    idle();
    drive_read(2, 1, 1'b1, 1'b0);
    #2;
    check_val("r2_cleared_busy", 32'(bus.BusyRS), 32'h0);
    check_val("r2_cleared_hazard", 32'(bus.Hazard), 32'h0);
    check_val("r2_data", 32'(bus.ReadRS), 32'h00A5);
    do_cycle();

    // same-edge issue and write to R4: new producer keeps it busy
    idle();
    drive_issue(4);
    drive_write(4, 16'h0077);
    do_cycle();
    idle();
    drive_read(4, 4, 1'b0, 1'b1);
    #2;
    check_val("r4_data", 32'(bus.ReadRS), 32'h0077);
    check_val("r4_busy", 32'(bus.BusyRT), 32'h1);
    do_cycle();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      drive_read(int'($urandom_range(DEPTH - 1)), int'($urandom_range(DEPTH - 1)),
                 1'($urandom_range(1)), 1'($urandom_range(1)));
      if ($urandom_range(9) < 4) drive_issue(int'($urandom_range(DEPTH - 1)));
      if ($urandom_range(1) == 1) drive_write(int'($urandom_range(DEPTH - 1)), WIDTH'($urandom));
      do_cycle();
    end
    idle();

    // wide instance: R15 round trip, R14 untouched, R0 ordinary
    bus_w.RegWrite = 1'b1; bus_w.RD = 4'd15; bus_w.WriteData = 32'hDEADBEEF;
    @(posedge Clock);
    @(negedge Clock);
    bus_w.RD = 4'd0; bus_w.WriteData = 32'h0000_0055;
    bus_w.RS = 4'd15; bus_w.RT = 4'd14;
    #2;
    check_val("wide_r15", bus_w.ReadRS, 32'hDEADBEEF);
    check_val("wide_r14", bus_w.ReadRT, 32'h0);
    @(posedge Clock);
    @(negedge Clock);
    bus_w.RegWrite = 1'b0;
    bus_w.RS = 4'd0;
    #2;
    check_val("wide_r0", bus_w.ReadRS, 32'h0000_0055);
    check_val("wide_r15_hold", bus_w.ReadRT, 32'h0);
    bus_w.RT = 4'd15;
    #1;
    check_val("wide_r15_again", bus_w.ReadRT, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
